// File: rtl/alu_pipe.sv
// Multi-stage integer ALU for the OoO backend: bubble-collapsing pipe with branch-mask tracking and flush.
// Optional macro ALU_SLT_EN adds slt (op 8) and sltu (op 9); without it ops 8-15 return 0.
package alu_pipe_pkg;
  localparam int MAX_BR_W = 16;

  typedef struct packed {
    logic [MAX_BR_W-1:0] branch_mask;
    logic [5:0]          rob_idx;
    logic [6:0]          pdst;
    logic                rf_wen;
  } uop_meta_t;

  typedef struct packed {
    uop_meta_t  meta;
    logic [3:0] fu_code;
  } issue_stage_t;
endpackage

module alu_pipe
  import alu_pipe_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int STAGES = 2,
  parameter int BR_W   = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    brb_broadcast,
  input  logic [$clog2(BR_W)-1:0] brb_tag,
  input  logic                    brb_clean,
  input  logic                    brb_kill,
  input  logic                    flush,
  input  issue_stage_t            istage,
  input  logic [3:0]              alu_op,
  input  logic [XLEN-1:0]         alu_a,
  input  logic [XLEN-1:0]         alu_b,
  input  logic                    ivalid,
  output logic                    iready,
  output issue_stage_t            ostage,
  output logic [XLEN-1:0]         oresult,
  output logic                    ovalid,
  input  logic                    oready
);

  localparam int SH_W = $clog2(XLEN);

  function automatic logic [XLEN-1:0] alu_calc(input logic [3:0] op,
                                               input logic [XLEN-1:0] a,
                                               input logic [XLEN-1:0] b);
    logic signed [XLEN-1:0] sa;
    logic [SH_W-1:0]        sh;
    logic [XLEN-1:0]        res;
    sa  = a;
    sh  = b[SH_W-1:0];
    res = '0;
    case (op)
      4'd0:    res = a + b;
      4'd1:    res = a << sh;
      4'd2:    res = sa >>> sh;
      4'd3:    res = a - b;
      4'd4:    res = a ^ b;
      4'd5:    res = a >> sh;
      4'd6:    res = a | b;
      4'd7:    res = a & b;
`ifdef ALU_SLT_EN
      4'd8:    res = {{(XLEN-1){1'b0}}, (sa < $signed(b))};
      4'd9:    res = {{(XLEN-1){1'b0}}, (a < b)};
`endif
      default: res = '0;
    endcase
    return res;
  endfunction

  function automatic logic br_hit(input issue_stage_t s, input logic [BR_W-1:0] oh);
    return |(s.meta.branch_mask[BR_W-1:0] & oh);
  endfunction

  function automatic issue_stage_t br_clear(input issue_stage_t s, input logic [BR_W-1:0] oh);
    issue_stage_t r;
    r = s;
    r.meta.branch_mask[BR_W-1:0] = s.meta.branch_mask[BR_W-1:0] & ~oh;
    return r;
  endfunction

  logic [STAGES-1:0]  r_vld_p;
  issue_stage_t       r_stage_p [STAGES];
  logic [XLEN-1:0]    r_res_p   [STAGES];

  logic [BR_W-1:0]    w_tag_oh;
  logic [BR_W-1:0]    w_clean_oh;
  logic               w_kill_en;
  logic [STAGES-1:0]  w_kill_p;
  logic [STAGES-1:0]  w_eff_p;
  logic [STAGES-1:0]  w_move_p;
  logic [STAGES-1:0]  w_accept_p;
  issue_stage_t       w_held_p  [STAGES];
  logic               w_in_kill;
  issue_stage_t       w_in_stage;
  logic [XLEN-1:0]    w_in_res;
  logic [STAGES-1:0]  w_src_vld_p;
  issue_stage_t       w_src_stage_p [STAGES];
  logic [XLEN-1:0]    w_src_res_p   [STAGES];

  // Clean wins over kill when both are raised for the same tag.
  assign w_tag_oh   = brb_broadcast ? (BR_W'(1) << brb_tag) : '0;
  assign w_clean_oh = brb_clean ? w_tag_oh : '0;
  assign w_kill_en  = brb_kill & ~brb_clean;

  assign w_in_kill  = br_hit(istage, w_tag_oh) & w_kill_en;
  assign w_in_stage = br_clear(istage, w_clean_oh);
  assign w_in_res   = alu_calc(alu_op, alu_a, alu_b);

  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      w_kill_p[k] = br_hit(r_stage_p[k], w_tag_oh) & w_kill_en;
      w_eff_p[k]  = r_vld_p[k] & ~w_kill_p[k];
      w_held_p[k] = br_clear(r_stage_p[k], w_clean_oh);
    end
  end

  // Ready ripples back from the consumer; an entry being killed counts as empty.
  always_comb begin
    logic v_free;
    v_free     = oready;
    w_move_p   = '0;
    w_accept_p = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      w_move_p[k]   = w_eff_p[k] & v_free;
      w_accept_p[k] = ~w_eff_p[k] | v_free;
      v_free        = w_accept_p[k];
    end
  end

  always_comb begin
    w_src_vld_p[0]   = ivalid & ~w_in_kill;
    w_src_stage_p[0] = w_in_stage;
    w_src_res_p[0]   = w_in_res;
    for (int k = 1; k < STAGES; k++) begin
      w_src_vld_p[k]   = w_move_p[k-1];
      w_src_stage_p[k] = w_held_p[k-1];
      w_src_res_p[k]   = r_res_p[k-1];
    end
  end

  // Stage boundary: valid bits (control, reset and flush only act here).
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_vld_p <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        r_vld_p[k] <= w_accept_p[k] ? w_src_vld_p[k] : w_eff_p[k];
      end
    end
  end

  // Stage boundary: payload registers; held entries still take branch-mask updates.
  always_ff @(posedge clk) begin
    for (int k = 0; k < STAGES; k++) begin
      if (w_accept_p[k] && w_src_vld_p[k]) begin
        r_stage_p[k] <= w_src_stage_p[k];
        r_res_p[k]   <= w_src_res_p[k];
      end else begin
        r_stage_p[k] <= w_held_p[k];
      end
    end
  end

  assign iready  = w_accept_p[0];
  assign ovalid  = r_vld_p[STAGES-1];
  assign ostage  = r_stage_p[STAGES-1];
  assign oresult = r_res_p[STAGES-1];

endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe (XLEN=32, STAGES=2, BR_W=4): latency, throughput, stall, branch, flush, reset.
module tb_alu_pipe;
  import alu_pipe_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  logic         brb_broadcast;
  logic [1:0]   brb_tag;
  logic         brb_clean;
  logic         brb_kill;
  logic         flush;
  issue_stage_t istage;
  logic [3:0]   alu_op;
  logic [31:0]  alu_a;
  logic [31:0]  alu_b;
  logic         ivalid;
  logic         iready;
  issue_stage_t ostage;
  logic [31:0]  oresult;
  logic         ovalid;
  logic         oready;

  int n_tests = 0;
  int n_fail  = 0;

  alu_pipe #(.XLEN(32), .STAGES(2), .BR_W(4)) dut (
    .clk(clk), .rst(rst),
    .brb_broadcast(brb_broadcast), .brb_tag(brb_tag),
    .brb_clean(brb_clean), .brb_kill(brb_kill),
    .flush(flush), .istage(istage),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .ivalid(ivalid), .iready(iready),
    .ostage(ostage), .oresult(oresult), .ovalid(ovalid), .oready(oready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [3:0] mask, input logic [5:0] id);
    ivalid = v;
    alu_op = op;
    alu_a  = a;
    alu_b  = b;
    istage = '0;
    istage.meta.branch_mask[3:0] = mask;
    istage.meta.rob_idx = id;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 4'd0, 32'd0, 32'd0, 4'd0, 6'd0);
  endtask

  task automatic brb(input logic bc, input logic [1:0] tag, input logic cl, input logic kl);
    brb_broadcast = bc;
    brb_tag       = tag;
    brb_clean     = cl;
    brb_kill      = kl;
  endtask

  // Single op into an empty pipe with oready high; result appears two edges later.
  task automatic run1(input string tag, input logic [3:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] exp);
    oready = 1'b1;
    drive(1'b1, op, a, b, 4'd0, 6'd5);
    tick();
    idle();
    tick();
    check({tag, "_vld"}, ovalid, 1'b1);
    check(tag, oresult, exp);
    tick();
  endtask

  logic [3:0]  v_op  [8] = '{4'd0, 4'd3, 4'd2, 4'd1, 4'd5, 4'd4, 4'd6, 4'd7};
  logic [31:0] v_a   [8] = '{32'd5, 32'd0, 32'h8000_0000, 32'd1, 32'h8000_0000,
                             32'hF0F0_F0F0, 32'h1234_0000, 32'hDEAD_BEEF};
  logic [31:0] v_b   [8] = '{32'd7, 32'd1, 32'd4, 32'd31, 32'h24,
                             32'hFF00_FF00, 32'h0000_5678, 32'h0000_FFFF};
  logic [31:0] v_exp [8] = '{32'h0000_000C, 32'hFFFF_FFFF, 32'hF800_0000, 32'h8000_0000,
                             32'h0800_0000, 32'h0FF0_0FF0, 32'h1234_5678, 32'h0000_BEEF};

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    oready = 1'b0;
    brb(1'b0, 2'd0, 1'b0, 1'b0);
    idle();
    tick();
    tick();
    check("rst_ovalid", ovalid, 1'b0);
    check("rst_iready", iready, 1'b1);
    rst = 1'b0;
    tick();
    check("idle_ovalid", ovalid, 1'b0);

    // Latency: add 5+7 shows up two edges after issue.
    oready = 1'b1;
    drive(1'b1, 4'd0, 32'd5, 32'd7, 4'd0, 6'd1);
    check("lat_iready", iready, 1'b1);
    tick();
    idle();
    check("lat_c1_ovalid", ovalid, 1'b0);
    tick();
    check("lat_ovalid", ovalid, 1'b1);
    check("lat_result", oresult, 32'd12);
    check("lat_id", ostage.meta.rob_idx, 6'd1);
    tick();
    check("lat_drain", ovalid, 1'b0);

    // Back-to-back eight ops.
    for (int i = 0; i <= 8; i++) begin
      if (i < 8) begin
        drive(1'b1, v_op[i], v_a[i], v_b[i], 4'd0, 6'(i + 8));
        check("b2b_iready", iready, 1'b1);
      end else begin
        idle();
      end
      tick();
      if (i >= 1) begin
        check("b2b_ovalid", ovalid, 1'b1);
        check("b2b_result", oresult, v_exp[i-1]);
        check("b2b_id", ostage.meta.rob_idx, 6'(i + 7));
      end
    end
    tick();
    check("b2b_drain", ovalid, 1'b0);

    // Stall: fill, hold oready low five cycles, then release.
    oready = 1'b0;
    drive(1'b1, 4'd0, 32'd1, 32'd2, 4'd0, 6'd20);
    tick();
    drive(1'b1, 4'd3, 32'd10, 32'd3, 4'd0, 6'd21);
    check("stall_fill_iready", iready, 1'b1);
    tick();
    drive(1'b1, 4'd4, 32'hFF, 32'h0F, 4'd0, 6'd22);
    check("stall_full_iready", iready, 1'b0);
    for (int i = 0; i < 5; i++) begin
      check("stall_ovalid", ovalid, 1'b1);
      check("stall_result", oresult, 32'd3);
      check("stall_id", ostage.meta.rob_idx, 6'd20);
      check("stall_iready", iready, 1'b0);
      tick();
    end
    oready = 1'b1;
    #1;
    check("release_iready", iready, 1'b1);
    tick();
    idle();
    check("drain_b_vld", ovalid, 1'b1);
    check("drain_b_res", oresult, 32'd7);
    check("drain_b_id", ostage.meta.rob_idx, 6'd21);
    tick();
    check("drain_c_vld", ovalid, 1'b1);
    check("drain_c_res", oresult, 32'h0000_00F0);
    check("drain_c_id", ostage.meta.rob_idx, 6'd22);
    tick();
    check("drain_empty", ovalid, 1'b0);

    // Kill on tag 1 squashes both held entries and the one being issued.
    oready = 1'b0;
    drive(1'b1, 4'd0, 32'd100, 32'd1, 4'b0010, 6'd30);
    tick();
    drive(1'b1, 4'd0, 32'd200, 32'd2, 4'b0010, 6'd31);
    tick();
    brb(1'b1, 2'd1, 1'b0, 1'b1);
    drive(1'b1, 4'd0, 32'd300, 32'd3, 4'b0010, 6'd32);
    check("kill_iready", iready, 1'b1);
    tick();
    brb(1'b0, 2'd0, 1'b0, 1'b0);
    idle();
    oready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("kill_ovalid", ovalid, 1'b0);
      tick();
    end

    // Clean on tag 1 (kill also raised) clears held masks; other bits survive.
    oready = 1'b0;
    drive(1'b1, 4'd0, 32'd1, 32'd1, 4'b0010, 6'd40);
    tick();
    drive(1'b1, 4'd1, 32'd3, 32'd2, 4'b1010, 6'd41);
    tick();
    idle();
    brb(1'b1, 2'd1, 1'b1, 1'b1);
    tick();
    brb(1'b0, 2'd0, 1'b0, 1'b0);
    check("clean_a_vld", ovalid, 1'b1);
    check("clean_a_res", oresult, 32'd2);
    check("clean_a_mask", ostage.meta.branch_mask, 16'h0000);
    oready = 1'b1;
    tick();
    check("clean_b_vld", ovalid, 1'b1);
    check("clean_b_res", oresult, 32'd12);
    check("clean_b_mask", ostage.meta.branch_mask, 16'h0008);
    check("clean_b_id", ostage.meta.rob_idx, 6'd41);
    tick();
    check("clean_drain", ovalid, 1'b0);

    // Clean applied to the entry captured from istage.
    drive(1'b1, 4'd6, 32'hA0, 32'h0B, 4'b0100, 6'd50);
    brb(1'b1, 2'd2, 1'b1, 1'b0);
    tick();
    brb(1'b0, 2'd0, 1'b0, 1'b0);
    idle();
    tick();
    check("inclean_vld", ovalid, 1'b1);
    check("inclean_res", oresult, 32'h0000_00AB);
    check("inclean_mask", ostage.meta.branch_mask, 16'h0000);

    // Kill on a tag the entry does not depend on leaves it alone.
    drive(1'b1, 4'd0, 32'd9, 32'd9, 4'b0001, 6'd51);
    brb(1'b1, 2'd3, 1'b0, 1'b1);
    tick();
    brb(1'b0, 2'd0, 1'b0, 1'b0);
    idle();
    tick();
    check("nokill_vld", ovalid, 1'b1);
    check("nokill_res", oresult, 32'd18);
    check("nokill_mask", ostage.meta.branch_mask, 16'h0001);
    tick();

    // Flush with pipe full and stalled.
    oready = 1'b0;
    drive(1'b1, 4'd0, 32'd1, 32'd0, 4'd0, 6'd60);
    tick();
    drive(1'b1, 4'd0, 32'd2, 32'd0, 4'd0, 6'd61);
    tick();
    idle();
    flush = 1'b1;
    #1;
    check("flush_full_iready", iready, 1'b0);
    tick();
    flush = 1'b0;
    #1;
    check("flush_ovalid", ovalid, 1'b0);
    check("flush_iready", iready, 1'b1);
    tick();
    check("flush_ovalid2", ovalid, 1'b0);

    // Flush discards an op handshaking in the same cycle.
    oready = 1'b1;
    drive(1'b1, 4'd0, 32'd3, 32'd3, 4'd0, 6'd62);
    flush = 1'b1;
    #1;
    check("flush_in_iready", iready, 1'b1);
    tick();
    flush = 1'b0;
    idle();
    check("flush_in_vld1", ovalid, 1'b0);
    tick();
    check("flush_in_vld2", ovalid, 1'b0);

    // Reset mid-stall drops held entries.
    oready = 1'b0;
    drive(1'b1, 4'd0, 32'd4, 32'd0, 4'd0, 6'd7);
    tick();
    drive(1'b1, 4'd0, 32'd5, 32'd0, 4'd0, 6'd8);
    tick();
    idle();
    check("prerst_vld", ovalid, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("midrst_ovalid", ovalid, 1'b0);
    check("midrst_iready", iready, 1'b1);
    tick();
    check("midrst_ovalid2", ovalid, 1'b0);

    // Wraparound and extended op codes.
    run1("add_wrap", 4'd0, 32'hFFFF_FFFF, 32'd2, 32'd1);
`ifdef ALU_SLT_EN
    run1("slt", 4'd8, 32'hFFFF_FFFF, 32'd1, 32'd1);
    run1("sltu", 4'd9, 32'hFFFF_FFFF, 32'd1, 32'd0);
    run1("slt_pos", 4'd8, 32'd1, 32'hFFFF_FFFF, 32'd0);
`else
    run1("op8", 4'd8, 32'hFFFF_FFFF, 32'd1, 32'd0);
    run1("op9", 4'd9, 32'd0, 32'd1, 32'd0);
`endif
    run1("op15", 4'd15, 32'h1234_5678, 32'h1, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
